// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Round-robin arbiter that shares the single write port of a
//             4x8 register file between NREQ writeback requesters
//             (ALU, load unit, CSR path, ...). The winning request is
//             registered into a one-cycle write stage. Cycles with two or
//             more requesters valid are counted in a saturating counter.
//  Ports    : clk, rst_n (async, active low)
//             req_valid/req_ready       per-requester valid/ready handshake
//             req_addr/req_data         packed per-requester address/data
//             rf_we/rf_wr_addr/rf_wr_data  registered write port
//             rd_addr1/2, rf_rd_data1/2 register file read mirror (in)
//             rd_data1/2                read data seen by consumers
//             conflict_cnt              saturating contention-cycle count
//  Config   : define WB_BYPASS_EN to forward the staged write onto the
//             read data outputs; undefined gives a pure pass-through.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 2,
  parameter int DW   = 8,
  parameter int CNTW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic               rf_we,
  output logic [AW-1:0]      rf_wr_addr,
  output logic [DW-1:0]      rf_wr_data,
  input  logic [AW-1:0]      rd_addr1,
  input  logic [AW-1:0]      rd_addr2,
  input  logic [DW-1:0]      rf_rd_data1,
  input  logic [DW-1:0]      rf_rd_data2,
  output logic [DW-1:0]      rd_data1,
  output logic [DW-1:0]      rd_data2,
  output logic [CNTW-1:0]    conflict_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            rf_we_q;
  logic [AW-1:0]   rf_wr_addr_q;
  logic [DW-1:0]   rf_wr_data_q;
  logic [CNTW-1:0] conflict_q, conflict_d;

  logic [NREQ-1:0] w_grant;
  logic            w_found;
  logic [PW-1:0]   w_gidx;
  logic            w_conflict;

  // Rotating priority search: start at rr_ptr and wrap modulo NREQ.
  always_comb begin
    int idx;
    w_grant = '0;
    w_found = 1'b0;
    w_gidx  = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && req_valid[idx[PW-1:0]]) begin
        w_found                 = 1'b1;
        w_gidx                  = idx[PW-1:0];
        w_grant[idx[PW-1:0]]    = 1'b1;
      end
    end
  end

  // Ready is held low while reset is asserted even with valid requests.
  assign req_ready = w_grant & {NREQ{rst_n}};

  always_comb begin
    int nvalid;
    nvalid = 0;
    for (int i = 0; i < NREQ; i++) begin
      nvalid = nvalid + int'(req_valid[i]);
    end
    w_conflict = (nvalid >= 2);
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (w_found) begin
      rr_ptr_d = (int'(w_gidx) == NREQ - 1) ? '0 : w_gidx + 1'b1;
    end
  end

  // Saturate rather than wrap.
  always_comb begin
    conflict_d = conflict_q;
    if (w_conflict && (conflict_q != {CNTW{1'b1}})) begin
      conflict_d = conflict_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      rf_we_q      <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
      conflict_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      conflict_q <= conflict_d;
      rf_we_q    <= w_found;
      // Address/data only move on a transfer; they hold otherwise.
      if (w_found) begin
        rf_wr_addr_q <= req_addr[w_gidx*AW +: AW];
        rf_wr_data_q <= req_data[w_gidx*DW +: DW];
      end
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_wr_addr   = rf_wr_addr_q;
  assign rf_wr_data   = rf_wr_data_q;
  assign conflict_cnt = conflict_q;

`ifdef WB_BYPASS_EN
  // Forward the staged write so readers never see the stale value.
  assign rd_data1 = (rf_we_q && (rf_wr_addr_q == rd_addr1)) ? rf_wr_data_q : rf_rd_data1;
  assign rd_data2 = (rf_we_q && (rf_wr_addr_q == rd_addr2)) ? rf_wr_data_q : rf_rd_data2;
`else
  assign rd_data1 = rf_rd_data1;
  assign rd_data2 = rf_rd_data2;
  // Read addresses only matter for forwarding.
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_addr1, rd_addr2};
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Randomized scoreboard bench for regfile_wb_arbiter with a
//             behavioural register file and reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 2;
  localparam int DW   = 8;
  localparam int CNTW = 8;
  localparam int CMAX = (1 << CNTW) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               rf_we;
  logic [AW-1:0]      rf_wr_addr;
  logic [DW-1:0]      rf_wr_data;
  logic [AW-1:0]      rd_addr1, rd_addr2;
  logic [DW-1:0]      rf_rd_data1, rf_rd_data2;
  logic [DW-1:0]      rd_data1, rd_data2;
  logic [CNTW-1:0]    conflict_cnt;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .conflict_cnt(conflict_cnt)
  );

  // Behavioural 4x8 register file fed by the DUT write port.
  logic         init_mem;
  logic [DW-1:0] real_rf [4];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 4; i++) real_rf[i] <= '0;
    end else if (rf_we) begin
      real_rf[rf_wr_addr] <= rf_wr_data;
    end
  end
  assign rf_rd_data1 = real_rf[rd_addr1];
  assign rf_rd_data2 = real_rf[rd_addr2];

  // Reference model state.
  typedef struct {
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;
  exp_t          q[$];
  int            m_ptr, m_cnt;
  logic [DW-1:0] ref_mem [4];
  bit            pend_v;
  logic [AW-1:0] pend_a;
  logic [DW-1:0] pend_d;
  bit            r_v [NREQ];
  logic [AW-1:0] r_a [NREQ];
  logic [DW-1:0] r_d [NREQ];

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++) begin
      if (r_v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
`ifdef WB_BYPASS_EN
    if (pend_v && pend_a == a) return pend_d;
`endif
    return ref_mem[a];
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = r_v[i];
      req_addr[i*AW +: AW] = r_a[i];
      req_data[i*DW +: DW] = r_d[i];
    end
  endtask

  // One clock of stimulus: refresh idle requesters, check combinational
  // outputs against the model, push the expected write, advance the model.
  task automatic cycle(input int pv, input bit force_all);
    int g, nv;
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (!r_v[i]) begin
        r_v[i] = force_all || ($urandom_range(99) < pv);
        r_a[i] = AW'($urandom_range(3));
        r_d[i] = DW'($urandom_range(255));
      end
    end
    drive_inputs();
    rd_addr1 = AW'($urandom_range(3));
    rd_addr2 = AW'($urandom_range(3));
    #1;
    g = model_grant();
    check("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    check("rd_data1", 32'(rd_data1), 32'(model_read(rd_addr1)));
    check("rd_data2", 32'(rd_data2), 32'(model_read(rd_addr2)));
    e.we = (g >= 0);
    e.a  = (g >= 0) ? r_a[g] : '0;
    e.d  = (g >= 0) ? r_d[g] : '0;
    q.push_back(e);
    nv = 0;
    for (int i = 0; i < NREQ; i++) nv += int'(r_v[i]);
    @(posedge clk);
    if (pend_v) ref_mem[pend_a] = pend_d;
    pend_v = (g >= 0);
    if (g >= 0) begin
      pend_a = r_a[g];
      pend_d = r_d[g];
      r_v[g] = 1'b0;
      m_ptr  = (g + 1) % NREQ;
    end
    if (nv >= 2 && m_cnt < CMAX) m_cnt++;
  endtask

  // Monitor: compare the registered write port and counter after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en && rst_n) begin
      check("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
      if (q.size() > 0) begin
        e = q.pop_front();
        check("rf_we", 32'(rf_we), 32'(e.we));
        if (e.we) begin
          check("rf_wr_addr", 32'(rf_wr_addr), 32'(e.a));
          check("rf_wr_data", 32'(rf_wr_data), 32'(e.d));
        end
      end else begin
        check("rf_we_unexpected", 32'(rf_we), 32'd0);
      end
    end
  end

  initial begin
    init_mem = 1'b1;
    rst_n    = 1'b0;
    rd_addr1 = '0;
    rd_addr2 = '0;
    m_ptr = 0; m_cnt = 0; pend_v = 1'b0; pend_a = '0; pend_d = '0;
    for (int i = 0; i < 4; i++) ref_mem[i] = '0;
    // Both requesters target reg3 while reset is held.
    for (int i = 0; i < NREQ; i++) begin
      r_v[i] = 1'b1;
      r_a[i] = AW'(3);
      r_d[i] = (i == 0) ? 8'h11 : 8'h22;
    end
    drive_inputs();
    repeat (3) @(posedge clk);
    #2;
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_we", 32'(rf_we), 32'd0);
    check("reset_cnt", 32'(conflict_cnt), 32'd0);
    #2;
    rst_n    = 1'b1;
    init_mem = 1'b0;
    mon_en   = 1'b1;

    // Same-address pair: 11 written first, then 22 wins.
    cycle(0, 1'b0);
    cycle(0, 1'b0);
    cycle(0, 1'b0);
    cycle(0, 1'b0);
    @(negedge clk);
    check("reg3_last_write", 32'(real_rf[3]), 32'h22);

    // Random traffic.
    for (int n = 0; n < 300; n++) cycle(60, 1'b0);

    // Sustained contention drives the counter into saturation.
    for (int n = 0; n < 300; n++) cycle(100, 1'b1);
    check("cnt_saturated", 32'(conflict_cnt), 32'(CMAX));

    // Reset in the middle of a staged write.
    cycle(100, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_we", 32'(rf_we), 32'd0);
    check("midrst_cnt", 32'(conflict_cnt), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd0);
    pend_v = 1'b0;
    m_ptr  = 0;
    m_cnt  = 0;
    q.delete();
    @(posedge clk);
    #4;
    check("midrst_we_hold", 32'(rf_we), 32'd0);
    rst_n = 1'b1;

    for (int n = 0; n < 100; n++) cycle(50, 1'b0);
    for (int n = 0; n < 6; n++) cycle(0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) check("final_reg", 32'(real_rf[i]), 32'(ref_mem[i]));

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
